popcount_burst_arbiter: RTL and testbench



---
 rtl/popcount_burst_arbiter.sv | 157 +++++++++++++++
 tb/tb_popcount_burst_arbiter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/popcount_burst_arbiter.sv
// Round-robin arbiter sharing one 16-bit popcount datapath among NUM_REQ requesters.
// A grant is held for a whole burst; the saturating burst total goes out on a result handshake.
module popcount_burst_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ACC_W   = 8,
  parameter int unsigned ID_W    = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [16*NUM_REQ-1:0]   req_data,
  input  logic [NUM_REQ-1:0]      req_last,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [ID_W-1:0]         res_id,
  output logic [ACC_W-1:0]        res_sum,
  output logic [ACC_W-1:0]        res_words,
  output logic                    res_sat
);

  localparam int unsigned PC_W = 5;
  localparam logic [ACC_W-1:0] SAT_MAX = '1;

  typedef enum logic [1:0] {IDLE, BURST, DONE} state_t;

  state_t             state, state_d;
  logic [ID_W-1:0]    rr_ptr, rr_ptr_d;
  logic [ACC_W-1:0]   acc, acc_d;
  logic [ACC_W-1:0]   words, words_d;
  logic [NUM_REQ-1:0] req_ready_d;
  logic               res_valid_d;
  logic [ID_W-1:0]    res_id_d;
  logic [ACC_W-1:0]   res_sum_d, res_words_d;
  logic               res_sat_d;

  logic [ID_W-1:0]    grant_c, hi_pick_c, lo_pick_c;
  logic               hi_found_c;
  logic [15:0]        word_c;
  logic [PC_W-1:0]    pc_c;
  logic               accept_c, last_c;
  logic [ACC_W:0]     acc_sum_c, words_sum_c;
  logic               acc_ovf_c, words_ovf_c;

  function automatic logic [PC_W-1:0] popcount16(input logic [15:0] w);
    logic [PC_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < 16; i++) begin
      cnt = cnt + {4'b0000, w[i]};
    end
    return cnt;
  endfunction

  // First valid requester at or after rr_ptr, wrapping to the lowest valid index.
  always_comb begin
    hi_found_c = 1'b0;
    hi_pick_c  = '0;
    lo_pick_c  = '0;
    for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        lo_pick_c = ID_W'(i);
        if (ID_W'(i) >= rr_ptr) begin
          hi_pick_c  = ID_W'(i);
          hi_found_c = 1'b1;
        end
      end
    end
    grant_c = hi_found_c ? hi_pick_c : lo_pick_c;
  end

  // req_ready is one-hot on the owner, so masking with it selects the owner's handshake.
  always_comb begin
    word_c   = req_data[{res_id, 4'b0000} +: 16];
    pc_c     = popcount16(word_c);
    accept_c = |(req_valid & req_ready);
    last_c   = |(req_valid & req_ready & req_last);
  end

  always_comb begin
    state_d     = state;
    rr_ptr_d    = rr_ptr;
    acc_d       = acc;
    words_d     = words;
    req_ready_d = req_ready;
    res_valid_d = res_valid;
    res_id_d    = res_id;
    res_sum_d   = res_sum;
    res_words_d = res_words;
    res_sat_d   = res_sat;
    acc_sum_c   = {1'b0, acc} + (ACC_W+1)'(pc_c);
    words_sum_c = {1'b0, words} + (ACC_W+1)'(1);
    acc_ovf_c   = acc_sum_c > {1'b0, SAT_MAX};
    words_ovf_c = words_sum_c > {1'b0, SAT_MAX};

    unique case (state)
      IDLE: begin
        if (|req_valid) begin
          res_id_d    = grant_c;
          acc_d       = '0;
          words_d     = '0;
          res_sat_d   = 1'b0;
          req_ready_d = NUM_REQ'(1) << grant_c;
          state_d     = BURST;
        end
      end
      BURST: begin
        if (accept_c) begin
          acc_d     = acc_ovf_c ? SAT_MAX : acc_sum_c[ACC_W-1:0];
          words_d   = words_ovf_c ? SAT_MAX : words_sum_c[ACC_W-1:0];
          res_sat_d = res_sat | acc_ovf_c | words_ovf_c;
          if (last_c) begin
            res_sum_d   = acc_d;
            res_words_d = words_d;
            res_valid_d = 1'b1;
            req_ready_d = '0;
            state_d     = DONE;
          end
        end
      end
      DONE: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          rr_ptr_d    = (res_id == ID_W'(NUM_REQ - 1)) ? '0 : res_id + ID_W'(1);
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      acc       <= '0;
      words     <= '0;
      req_ready <= '0;
      res_valid <= 1'b0;
      res_id    <= '0;
      res_sum   <= '0;
      res_words <= '0;
      res_sat   <= 1'b0;
    end else begin
      state     <= state_d;
      rr_ptr    <= rr_ptr_d;
      acc       <= acc_d;
      words     <= words_d;
      req_ready <= req_ready_d;
      res_valid <= res_valid_d;
      res_id    <= res_id_d;
      res_sum   <= res_sum_d;
      res_words <= res_words_d;
      res_sat   <= res_sat_d;
    end
  end

endmodule

// File: tb/tb_popcount_burst_arbiter.sv
// Bench for popcount_burst_arbiter: directed scenarios plus random traffic,
// checked every cycle against a burst-level reference model.
module tb_popcount_burst_arbiter;

  localparam int N     = 4;
  localparam int ACC_W = 8;
  localparam int ID_W  = 2;
  localparam int SATV  = 255;
  localparam int M_IDLE = 0, M_BURST = 1, M_DONE = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req_valid;
  logic [16*N-1:0]   req_data;
  logic [N-1:0]      req_last;
  logic [N-1:0]      req_ready;
  logic              res_valid;
  logic              res_ready;
  logic [ID_W-1:0]   res_id;
  logic [ACC_W-1:0]  res_sum;
  logic [ACC_W-1:0]  res_words;
  logic              res_sat;

  popcount_burst_arbiter #(.NUM_REQ(N), .ACC_W(ACC_W), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
    .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
    .res_sum(res_sum), .res_words(res_words), .res_sat(res_sat)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Pending burst words per requester, with a one-cycle gap marker before a word.
  logic [15:0] pdata [N][$];
  bit          pgap  [N][$];

  // Reference model state
  int m_state, m_ptr, m_g, m_sum, m_words;
  int exp_id, exp_sum, exp_words;
  bit exp_sat;
  int hold_low;
  bit rand_ready;

  // Completed bursts as seen on the result port at the handshake
  int served[$];
  int got_sum[$];
  int got_words[$];
  int got_sat[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int first_from(input logic [N-1:0] v, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic load_word(input int i, input logic [15:0] d, input bit gap);
    pdata[i].push_back(d);
    pgap[i].push_back(gap);
  endtask

  task automatic clear_model();
    m_state = M_IDLE; m_ptr = 0; m_g = 0; m_sum = 0; m_words = 0;
    for (int i = 0; i < N; i++) begin
      pdata[i].delete();
      pgap[i].delete();
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req_valid = '0; req_last = '0; res_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    clear_model();
    check("rst_req_ready", 32'(req_ready), 0);
    check("rst_res_valid", 32'(res_valid), 0);
    check("rst_res_id",    32'(res_id), 0);
    check("rst_res_sum",   32'(res_sum), 0);
    check("rst_res_words", 32'(res_words), 0);
    check("rst_res_sat",   32'(res_sat), 0);
  endtask

  // One clock: check outputs against the model, drive inputs, advance the model.
  task automatic cycle();
    logic [N-1:0] v;
    logic [N-1:0] exp_rdy;
    bit rr;
    bit is_last;
    @(negedge clk);
    exp_rdy = (m_state == M_BURST) ? (N'(1) << m_g) : '0;
    check("req_ready", 32'(req_ready), 32'(exp_rdy));
    check("res_valid", 32'(res_valid), 32'(m_state == M_DONE));
    if (m_state == M_DONE) begin
      check("res_id",    32'(res_id), 32'(exp_id));
      check("res_sum",   32'(res_sum), 32'(exp_sum));
      check("res_words", 32'(res_words), 32'(exp_words));
      check("res_sat",   32'(res_sat), 32'(exp_sat));
    end

    v = '0;
    req_last = '0;
    for (int i = 0; i < N; i++) begin
      if (pdata[i].size() > 0) begin
        if (m_state == M_BURST && m_g == i && pgap[i][0]) begin
          pgap[i][0] = 1'b0;
        end else begin
          v[i] = 1'b1;
        end
        req_data[16*i +: 16] = pdata[i][0];
        req_last[i] = (pdata[i].size() == 1);
      end else begin
        req_data[16*i +: 16] = 16'($urandom);
        req_last[i] = 1'($urandom);
      end
    end
    req_valid = v;

    if (m_state == M_DONE && hold_low > 0) begin
      rr = 1'b0;
      hold_low--;
    end else begin
      rr = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
    res_ready = rr;

    case (m_state)
      M_IDLE: begin
        if (|v) begin
          m_g = first_from(v, m_ptr);
          m_sum = 0; m_words = 0;
          m_state = M_BURST;
        end
      end
      M_BURST: begin
        if (v[m_g]) begin
          is_last = (pdata[m_g].size() == 1);
          m_sum += $countones(pdata[m_g][0]);
          m_words++;
          void'(pdata[m_g].pop_front());
          void'(pgap[m_g].pop_front());
          if (is_last) begin
            exp_id    = m_g;
            exp_sum   = (m_sum > SATV) ? SATV : m_sum;
            exp_words = (m_words > SATV) ? SATV : m_words;
            exp_sat   = (m_sum > SATV) || (m_words > SATV);
            m_state   = M_DONE;
          end
        end
      end
      default: begin
        if (rr) begin
          served.push_back(int'(res_id));
          got_sum.push_back(int'(res_sum));
          got_words.push_back(int'(res_words));
          got_sat.push_back(int'(res_sat));
          m_ptr = (m_g + 1) % N;
          m_state = M_IDLE;
        end
      end
    endcase
  endtask

  task automatic run_until(input int target);
    int budget = 400;
    while (served.size() < target && budget > 0) begin
      cycle();
      budget--;
    end
    if (served.size() < target) check("timeout_served", 32'(served.size()), 32'(target));
  endtask

  task automatic check_last(input string tag, input int id, input int sum, input int wds, input int sat);
    check({tag, "_id"},    32'(served[$]), 32'(id));
    check({tag, "_sum"},   32'(got_sum[$]), 32'(sum));
    check({tag, "_words"}, 32'(got_words[$]), 32'(wds));
    check({tag, "_sat"},   32'(got_sat[$]), 32'(sat));
  endtask

  initial begin
    int base;
    int budget;
    bit busy;
    rst = 1'b1; req_valid = '0; req_data = '0; req_last = '0; res_ready = 1'b0;
    hold_low = 0; rand_ready = 1'b0;
    clear_model();
    do_reset();

    // Single full word, minimum-latency burst
    load_word(0, 16'hFFFF, 1'b0);
    run_until(1);
    check_last("one_word", 0, 16, 1, 0);

    // Three words with an idle gap before the last one
    load_word(2, 16'h0001, 1'b0);
    load_word(2, 16'h00FF, 1'b0);
    load_word(2, 16'hF0F0, 1'b1);
    run_until(2);
    check_last("gap_burst", 2, 17, 3, 0);

    // Simultaneous requesters after reset: round-robin order 0, 3, then 0 again
    do_reset();
    base = served.size();
    load_word(0, 16'h0003, 1'b0);
    load_word(3, 16'h0007, 1'b0);
    run_until(base + 2);
    load_word(0, 16'h0001, 1'b0);
    load_word(3, 16'h8000, 1'b0);
    run_until(base + 4);
    check("rr_first",  32'(served[base]),     0);
    check("rr_second", 32'(served[base + 1]), 3);
    check("rr_third",  32'(served[base + 2]), 0);
    check("rr_fourth", 32'(served[base + 3]), 3);

    // Saturation of the sum accumulator
    for (int k = 0; k < 17; k++) load_word(1, 16'hFFFF, 1'b0);
    run_until(served.size() + 1);
    check_last("saturate", 1, 255, 17, 1);

    // Result backpressure with another requester waiting
    base = served.size();
    hold_low = 5;
    load_word(0, 16'h1234, 1'b0);
    load_word(1, 16'h0F0F, 1'b0);
    run_until(base + 2);
    check("bp_first_id",   32'(served[base]), 0);
    check("bp_first_sum",  32'(got_sum[base]), 5);
    check("bp_second_id",  32'(served[base + 1]), 1);
    check("bp_second_sum", 32'(got_sum[base + 1]), 8);

    // Reset in the middle of a burst discards it
    for (int k = 0; k < 4; k++) load_word(2, 16'hFFFF, 1'b0);
    budget = 50;
    while (!(m_state == M_BURST && m_words >= 2) && budget > 0) begin
      cycle();
      budget--;
    end
    if (budget == 0) check("timeout_mid_burst", 32'(m_words), 2);
    base = served.size();
    do_reset();
    for (int k = 0; k < 4; k++) cycle();
    check("no_result_after_rst", 32'(served.size()), 32'(base));
    load_word(0, 16'h000F, 1'b0);
    run_until(base + 1);
    check_last("after_rst", 0, 4, 1, 0);

    // Random traffic with random gaps, burst lengths and backpressure
    rand_ready = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (pdata[i].size() == 0 && $urandom_range(0, 7) == 0) begin
          if ($urandom_range(0, 15) == 0) begin
            for (int k = 0; k < 18; k++) load_word(i, 16'hFFFF, $urandom_range(0, 3) == 0);
          end else begin
            for (int k = 0; k < int'($urandom_range(1, 6)); k++)
              load_word(i, 16'($urandom), $urandom_range(0, 3) == 0);
          end
        end
      end
      cycle();
    end
    budget = 3000;
    busy = 1'b1;
    while (busy && budget > 0) begin
      cycle();
      budget--;
      busy = (m_state != M_IDLE);
      for (int i = 0; i < N; i++) if (pdata[i].size() > 0) busy = 1'b1;
    end
    if (busy) check("timeout_drain", 32'(m_state), 32'(M_IDLE));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
